// File: rtl/des_pkg.sv
// Shared DES constants and helpers: FIPS 46-3 permutation tables, S-boxes,
// per-round rotation amounts and the FSM state type.
package des_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} des_state_t;

  // Table entries are 1-based FIPS bit numbers, bit 1 being the MSB.
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Each box is stored row-major: entry = row * 16 + column.
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  // Decrypt starts from C0/D0 (= C16/D16), hence the leading zero.
  localparam logic [1:0] SHIFT_ENC [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [1:0] SHIFT_DEC [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [63:0] des_ip(input logic [63:0] blk);
    logic [63:0] res;
    res = 64'd0;
    for (int j = 0; j < 64; j++) res[63-j] = blk[64-IP_TBL[j]];
    return res;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] blk);
    logic [63:0] res;
    res = 64'd0;
    for (int j = 0; j < 64; j++) res[63-j] = blk[64-FP_TBL[j]];
    return res;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] key);
    logic [55:0] res;
    res = 56'd0;
    for (int j = 0; j < 56; j++) res[55-j] = key[64-PC1_TBL[j]];
    return res;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] cd);
    logic [47:0] res;
    res = 48'd0;
    for (int j = 0; j < 48; j++) res[47-j] = cd[56-PC2_TBL[j]];
    return res;
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s_out;
    logic [31:0] res;
    logic [5:0]  six;
    logic [5:0]  idx;
    x = 48'd0;
    for (int j = 0; j < 48; j++) x[47-j] = r[32-E_TBL[j]];
    x = x ^ k;
    s_out = 32'd0;
    for (int s = 0; s < 8; s++) begin
      six = x[47-6*s -: 6];
      idx = {six[5], six[0], six[4:1]};
      s_out[31-4*s -: 4] = 4'(SBOX[s][idx]);
    end
    res = 32'd0;
    for (int j = 0; j < 32; j++) res[31-j] = s_out[32-P_TBL[j]];
    return res;
  endfunction

  function automatic logic [27:0] des_rotl(input logic [27:0] x, input logic [1:0] amt);
    logic [27:0] res;
    case (amt)
      2'd1:    res = {x[26:0], x[27]};
      2'd2:    res = {x[25:0], x[27:26]};
      default: res = x;
    endcase
    return res;
  endfunction

  function automatic logic [27:0] des_rotr(input logic [27:0] x, input logic [1:0] amt);
    logic [27:0] res;
    case (amt)
      2'd1:    res = {x[0], x[27:1]};
      2'd2:    res = {x[1:0], x[27:2]};
      default: res = x;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES round: rotate C/D, derive the subkey, apply the
// Feistel step. Decrypt mode rotates right so the schedule runs backwards.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_in,
  input  logic [31:0] r_in,
  input  logic [27:0] c_in,
  input  logic [27:0] d_in,
  input  logic        mode,
  input  logic [1:0]  shift,
  output logic [31:0] l_out,
  output logic [31:0] r_out,
  output logic [27:0] c_out,
  output logic [27:0] d_out
);

  logic [27:0] c_rot;
  logic [27:0] d_rot;

  // Key rotation followed by the Feistel function on the rotated key.
  always_comb begin
    if (mode) begin
      c_rot = des_rotr(c_in, shift);
      d_rot = des_rotr(d_in, shift);
    end else begin
      c_rot = des_rotl(c_in, shift);
      d_rot = des_rotl(d_in, shift);
    end
    c_out = c_rot;
    d_out = d_rot;
    l_out = r_in;
    r_out = l_in ^ des_f(r_in, des_pc2({c_rot, d_rot}));
  end

endmodule

// File: rtl/des_iter_core.sv
// Folded DES engine: ROUNDS_PER_CYCLE chained rounds per clock, subkeys
// generated on the fly, valid/ready on both sides.
module des_iter_core
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  input  logic [63:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);

  localparam int         RPC       = ROUNDS_PER_CYCLE;
  localparam logic [4:0] RCNT_STEP = 5'(RPC);
  localparam logic [4:0] RCNT_LAST = 5'(16 - RPC);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
    $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  des_state_t  state_q, state_d;
  logic [4:0]  rcnt_q, rcnt_d;
  logic        mode_q, mode_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] data_out_q, data_out_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        out_valid_q, out_valid_d;

  logic [31:0] l_last, r_last;
  logic [27:0] c_last, d_last;

  for (genvar k = 0; k < RPC; k++) begin : g_round
    logic [31:0] l_i, r_i, l_o, r_o;
    logic [27:0] c_i, d_i, c_o, d_o;
    logic [3:0]  ridx;
    logic [1:0]  shift;

    if (k == 0) begin : g_first
      assign l_i = l_q;
      assign r_i = r_q;
      assign c_i = c_q;
      assign d_i = d_q;
    end else begin : g_next
      assign l_i = g_round[k-1].l_o;
      assign r_i = g_round[k-1].r_o;
      assign c_i = g_round[k-1].c_o;
      assign d_i = g_round[k-1].d_o;
    end

    // Global round index of this stage within the current group.
    assign ridx  = rcnt_q[3:0] + 4'(k);
    assign shift = mode_q ? SHIFT_DEC[ridx] : SHIFT_ENC[ridx];

    des_round u_round (
      .l_in  (l_i),
      .r_in  (r_i),
      .c_in  (c_i),
      .d_in  (d_i),
      .mode  (mode_q),
      .shift (shift),
      .l_out (l_o),
      .r_out (r_o),
      .c_out (c_o),
      .d_out (d_o)
    );
  end

  assign l_last = g_round[RPC-1].l_o;
  assign r_last = g_round[RPC-1].r_o;
  assign c_last = g_round[RPC-1].c_o;
  assign d_last = g_round[RPC-1].d_o;

  // Next-state and next-output computation for the IDLE/ROUND/DONE machine.
  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    mode_d     = mode_q;
    l_d        = l_q;
    r_d        = r_q;
    c_d        = c_q;
    d_d        = d_q;
    data_out_d = data_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          {l_d, r_d} = des_ip(data_in);
          {c_d, d_d} = des_pc1(key_in);
          mode_d     = decrypt;
          rcnt_d     = 5'd0;
          state_d    = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND: begin
        l_d    = l_last;
        r_d    = r_last;
        c_d    = c_last;
        d_d    = d_last;
        rcnt_d = rcnt_q + RCNT_STEP;
        if (rcnt_q == RCNT_LAST) begin
          data_out_d = des_fp({r_last, l_last});
          state_d    = DONE;
        end else begin
          state_d = ROUND;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == ROUND);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rcnt_q      <= 5'd0;
      mode_q      <= 1'b0;
      l_q         <= 32'd0;
      r_q         <= 32'd0;
      c_q         <= 28'd0;
      d_q         <= 28'd0;
      data_out_q  <= 64'd0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      mode_q      <= mode_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      data_out_q  <= data_out_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_des_iter_core.sv
// Bench for des_iter_core: five instances (1,2,4,8,16 rounds/cycle) driven in
// lockstep and checked against known answers and a behavioural DES model.
module tb_des_iter_core;
  import des_pkg::*;

  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid;
  logic        decrypt;
  logic        out_ready;
  logic [63:0] key_in;
  logic [63:0] data_in;

  logic [NI-1:0]       in_ready_w;
  logic [NI-1:0]       out_valid_w;
  logic [NI-1:0]       busy_w;
  logic [NI-1:0][63:0] data_out_w;

  int checks = 0;
  int errors = 0;

  logic [63:0]   res_a [NI];
  int            lat_a [NI];
  logic [NI-1:0] busy_seen;
  bit            job_timeout;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    des_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .decrypt   (decrypt),
      .key_in    (key_in),
      .data_in   (data_in),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .data_out  (data_out_w[g]),
      .busy      (busy_w[g])
    );
  end

  // Textbook DES: whole key schedule first, subkeys reversed for decryption.
  function automatic logic [63:0] ref_des(input logic [63:0] key, input logic [63:0] blk,
                                          input logic dec);
    logic [55:0] cd, cc, dd;
    logic [47:0] ks [16];
    logic [47:0] x, k;
    logic [63:0] ipb, pre, res;
    logic [31:0] l, r, t, s_out, f;
    logic [5:0]  six;
    int          tot;
    for (int j = 0; j < 56; j++) cd[55-j] = key[64-PC1_TBL[j]];
    cc  = {cd[55:28], cd[55:28]};
    dd  = {cd[27:0], cd[27:0]};
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      tot = tot + int'(SHIFT_ENC[i]);
      cd  = {cc[55-tot -: 28], dd[55-tot -: 28]};
      for (int j = 0; j < 48; j++) ks[i][47-j] = cd[56-PC2_TBL[j]];
    end
    for (int j = 0; j < 64; j++) ipb[63-j] = blk[64-IP_TBL[j]];
    l = ipb[63:32];
    r = ipb[31:0];
    for (int i = 0; i < 16; i++) begin
      k = dec ? ks[15-i] : ks[i];
      for (int j = 0; j < 48; j++) x[47-j] = r[32-E_TBL[j]];
      x = x ^ k;
      for (int s = 0; s < 8; s++) begin
        six = x[47-6*s -: 6];
        s_out[31-4*s -: 4] = 4'(SBOX[s][{six[5], six[0]} * 16 + six[4:1]]);
      end
      for (int j = 0; j < 32; j++) f[31-j] = s_out[32-P_TBL[j]];
      t = r;
      r = l ^ f;
      l = t;
    end
    pre = {r, l};
    for (int j = 0; j < 64; j++) res[63-j] = pre[64-FP_TBL[j]];
    return res;
  endfunction

  // Issues one request to all instances and records latency and result.
  task automatic run_job(input logic [63:0] key, input logic [63:0] blk, input logic dec);
    int found;
    @(negedge clk);
    key_in   = key;
    data_in  = blk;
    decrypt  = dec;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    key_in   = {$urandom, $urandom};
    data_in  = {$urandom, $urandom};
    decrypt  = ~dec;
    busy_seen = busy_w;
    for (int i = 0; i < NI; i++) lat_a[i] = -1;
    found = 0;
    job_timeout = 1'b0;
    for (int cyc = 1; cyc <= 40 && found < NI; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (lat_a[i] < 0 && out_valid_w[i]) begin
          lat_a[i] = cyc;
          res_a[i] = data_out_w[i];
          found++;
        end
      end
    end
    if (found < NI) job_timeout = 1'b1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; decrypt = 1'b0;
    key_in = 64'd0; data_in = 64'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if ({in_ready_w[i], out_valid_w[i], busy_w[i]} !== 3'b100 || data_out_w[i] !== 64'd0) begin
        errors++;
        $display("FAIL reset inst=%0d rdy/val/busy=%b data=%h exp 100/0", i,
                 {in_ready_w[i], out_valid_w[i], busy_w[i]}, data_out_w[i]);
      end
    end
  endtask

  task automatic test_known_answers();
    logic [63:0] kv [5] = '{64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 64'h0E329232EA6D0D73,
                            64'h0000000000000000, 64'h0101010101010101};
    logic [63:0] dv [5] = '{64'h0123456789ABCDEF, 64'h85E813540F0AB405, 64'h8787878787878787,
                            64'h0000000000000000, 64'h0000000000000000};
    logic [63:0] ev [5] = '{64'h85E813540F0AB405, 64'h0123456789ABCDEF, 64'h0000000000000000,
                            64'h8CA64DE9C1B123A7, 64'h8CA64DE9C1B123A7};
    logic        mv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int v = 0; v < 5; v++) begin
      run_job(kv[v], dv[v], mv[v]);
      checks++;
      if (job_timeout !== 1'b0) begin
        errors++;
        $display("FAIL kat_timeout vec=%0d got=%b exp=0", v, job_timeout);
      end
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (res_a[i] !== ev[v]) begin
          errors++;
          $display("FAIL kat_data vec=%0d inst=%0d got=%h exp=%h", v, i, res_a[i], ev[v]);
        end
        checks++;
        if (lat_a[i] !== (16 >> i)) begin
          errors++;
          $display("FAIL kat_latency vec=%0d inst=%0d got=%0d exp=%0d", v, i, lat_a[i], 16 >> i);
        end
        checks++;
        if (busy_seen[i] !== 1'b1) begin
          errors++;
          $display("FAIL kat_busy vec=%0d inst=%0d got=%b exp=1", v, i, busy_seen[i]);
        end
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] k1, p1, e1, k2, p2, e2;
    int          waited;
    k1 = {$urandom, $urandom}; p1 = {$urandom, $urandom}; e1 = ref_des(k1, p1, 1'b0);
    k2 = {$urandom, $urandom}; p2 = {$urandom, $urandom}; e2 = ref_des(k2, p2, 1'b1);
    @(negedge clk);
    key_in = k1; data_in = p1; decrypt = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    key_in = k2; data_in = p2; decrypt = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_w[0] !== 1'b1 || in_ready_w !== '0) begin
      errors++;
      $display("FAIL bp_ignore_in_valid busy0=%b in_ready=%b exp 1/00000", busy_w[0], in_ready_w);
    end
    waited = 0;
    while (out_valid_w !== '1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 40) begin
      errors++;
      $display("FAIL bp_timeout out_valid=%b exp=11111", out_valid_w);
    end
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (data_out_w[i] !== e1 || out_valid_w[i] !== 1'b1 || in_ready_w[i] !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold cyc=%0d inst=%0d data=%h val=%b rdy=%b exp %h/1/0", c, i,
                   data_out_w[i], out_valid_w[i], in_ready_w[i], e1);
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (in_ready_w[i] !== 1'b1 || out_valid_w[i] !== 1'b0 || data_out_w[i] !== e1) begin
        errors++;
        $display("FAIL bp_release inst=%0d rdy=%b val=%b data=%h exp 1/0/%h", i,
                 in_ready_w[i], out_valid_w[i], data_out_w[i], e1);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy_w !== '1 || in_ready_w !== '0) begin
      errors++;
      $display("FAIL bp_next_accept busy=%b rdy=%b exp 11111/00000", busy_w, in_ready_w);
    end
    waited = 0;
    while (out_valid_w !== '1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (data_out_w[i] !== e2) begin
        errors++;
        $display("FAIL bp_second_result inst=%0d got=%h exp=%h", i, data_out_w[i], e2);
      end
    end
    release_out();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    key_in = 64'h133457799BBCDFF1; data_in = 64'h0123456789ABCDEF; decrypt = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy got=%b exp=1", busy_w[0]);
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (out_valid_w[i] !== 1'b0 || data_out_w[i] !== 64'd0 || in_ready_w[i] !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_state inst=%0d val=%b data=%h rdy=%b exp 0/0/1", i,
                 out_valid_w[i], data_out_w[i], in_ready_w[i]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid_w !== '0) begin
        errors++;
        $display("FAIL rstmid_silent cyc=%0d out_valid=%b exp=00000", c, out_valid_w);
      end
    end
    run_job(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (job_timeout !== 1'b0 || res_a[i] !== 64'd0) begin
        errors++;
        $display("FAIL rstmid_fresh inst=%0d got=%h timeout=%b exp=0", i, res_a[i], job_timeout);
      end
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [63:0] k, pt, ct, exp_ct;
    for (int n = 0; n < 50; n++) begin
      k  = {$urandom, $urandom};
      pt = {$urandom, $urandom};
      exp_ct = ref_des(k, pt, 1'b0);
      run_job(k, pt, 1'b0);
      ct = res_a[0];
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (job_timeout !== 1'b0 || res_a[i] !== exp_ct) begin
          errors++;
          $display("FAIL b2b_enc n=%0d inst=%0d got=%h exp=%h", n, i, res_a[i], exp_ct);
        end
      end
      release_out();
      run_job(k, ct, 1'b1);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (job_timeout !== 1'b0 || res_a[i] !== pt) begin
          errors++;
          $display("FAIL b2b_dec n=%0d inst=%0d got=%h exp=%h", n, i, res_a[i], pt);
        end
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_known_answers();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
